// File: rtl/lcd_scanout.sv
// Scanout engine for the double-buffered LCD framebuffer. It drives sync and DE, the
// framebuffer read address, and the swap pulse. Optional LCD_SCANOUT_TESTPAT_EN adds an XOR test pattern.
module lcd_scanout #(
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 8,
   parameter int H_SYNC   = 4,
   parameter int H_BP     = 43,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 12
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef LCD_SCANOUT_TESTPAT_EN
   input  logic        test_en,
`endif
   input  logic        frame_ready,
   input  logic [7:0]  fb_data,
   output logic [31:0] rad,
   output logic        swap,
   output logic        frame_start,
   output logic [7:0]  lcd_data,
   output logic        lcd_hsync,
   output logic        lcd_vsync,
   output logic        lcd_de
);

   localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
   localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
   localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0] ADDR_MAX = 32'(H_ACTIVE * V_ACTIVE - 1);

   logic [15:0] h_cnt;
   logic [15:0] v_cnt;
   logic [31:0] addr_cnt;
   logic        h_last;
   logic        frame_last;
   logic        active_s0;
   logic        hs_s0;
   logic        vs_s0;
   logic        swap_point;
   logic        de1, hs1, vs1;
   logic        de2, hs2, vs2;
   logic [7:0]  pix;

   assign h_last     = (h_cnt == H_LAST);
   assign frame_last = h_last && (v_cnt == V_LAST);
   assign active_s0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_s0      = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_s0      = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign swap_point = (h_cnt == 16'd0) && (v_cnt == V_ACT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= 16'd0;
         v_cnt <= 16'd0;
      end else if (h_last) begin
         h_cnt <= 16'd0;
         v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
      end else begin
         h_cnt <= h_cnt + 16'd1;
      end
   end

   // addr_cnt tracks the counter stage; rad latches it only for active pixels and holds through blanking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_cnt <= 32'd0;
         rad      <= 32'd0;
      end else if (frame_last) begin
         addr_cnt <= 32'd0;
         rad      <= 32'd0;
      end else if (active_s0) begin
         rad <= addr_cnt;
         if (addr_cnt != ADDR_MAX) begin
            addr_cnt <= addr_cnt + 32'd1;
         end
      end
   end

`ifdef LCD_SCANOUT_TESTPAT_EN
   logic [7:0] pat1;
   logic [7:0] pat2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat1 <= 8'd0;
         pat2 <= 8'd0;
      end else begin
         pat1 <= h_cnt[7:0] ^ v_cnt[7:0];
         pat2 <= pat1;
      end
   end

   assign pix = test_en ? pat2 : fb_data;
`else
   assign pix = fb_data;
`endif

   // Flags ride two stages so they line up with RAM data, then everything lands in the panel registers together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de1         <= 1'b0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
         de2         <= 1'b0;
         hs2         <= 1'b0;
         vs2         <= 1'b0;
         frame_start <= 1'b0;
         swap        <= 1'b0;
         lcd_de      <= 1'b0;
         lcd_hsync   <= 1'b1;
         lcd_vsync   <= 1'b1;
         lcd_data    <= 8'd0;
      end else begin
         de1         <= active_s0;
         hs1         <= hs_s0;
         vs1         <= vs_s0;
         de2         <= de1;
         hs2         <= hs1;
         vs2         <= vs1;
         frame_start <= (h_cnt == 16'd0) && (v_cnt == 16'd0);
         swap        <= swap_point && frame_ready && !de1 && !de2;
         lcd_de      <= de2;
         lcd_hsync   <= ~hs2;
         lcd_vsync   <= ~vs2;
         lcd_data    <= de2 ? pix : 8'd0;
      end
   end

endmodule

// File: doc/lcd_scanout.md
# lcd_scanout

Read-side scanout engine for the double-buffered LCD framebuffer. It generates raw parallel-RGB LCD timing (hsync/vsync/DE) from the pixel clock and drives the framebuffer read address. It captures read data and presents it to the panel aligned with the sync signals. It also issues the buffer-swap pulse to the framebuffer during vertical blanking, so the front/back buffers never exchange mid-frame.

## Interface

**Parameters**

- `H_ACTIVE`, default 480: visible pixels per line.
- `H_FP`, default 8: horizontal front porch, in clocks.
- `H_SYNC`, default 4: hsync width, in clocks.
- `H_BP`, default 43: horizontal back porch, in clocks.
- `V_ACTIVE`, default 272: visible lines per frame.
- `V_FP`, default 4: vertical front porch, in lines.
- `V_SYNC`, default 4: vsync width, in lines.
- `V_BP`, default 12: vertical back porch, in lines.

**Ports**

- `clk` in, 1: pixel clock; the same clock feeds the framebuffer `rclk`.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `frame_ready` in, 1: writer level. It means "back buffer complete, swap wanted". It is held high until `swap` is seen.
- `fb_data` in, 8: framebuffer read data. It is registered RAM output, valid 1 clk after `rad`.
- `rad` out, 32: framebuffer read address.
- `swap` out, 1: one-clk pulse, registered; drives framebuffer `switch`.
- `frame_start` out, 1: one-clk pulse when the counters are at (0,0).
- `lcd_data` out, 8: pixel value to the panel.
- `lcd_hsync` out, 1: hsync, active-low.
- `lcd_vsync` out, 1: vsync, active-low.
- `lcd_de` out, 1: data enable, active-high.

## Operation

**Counters**
- `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- `v_cnt` runs 0..V_TOTAL-1 and advances when `h_cnt` wraps.
- Both counters are 16 bits wide. Parameter sums must be below 65536.

**Regions, evaluated at counter stage (S0)**
- Active when `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
- Hsync is asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vsync is asserted for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- Hsync keeps running during vertical blanking.

**Address generation**
- `rad` is a registered linear counter.
- It holds 0 at frame start.
- It increments by 1 after each active pixel, so it equals `v_cnt*H_ACTIVE+h_cnt` for active pixels.
- It is reloaded to 0 when the counters are at (H_TOTAL-1, V_TOTAL-1).
- Maximum value is H_ACTIVE*V_ACTIVE-1. `rad` never exceeds this.

**Blanking**
- `lcd_data` is forced to 0 whenever `lcd_de` is 0.

**Swap handshake**
- `frame_ready` is sampled only at S0 (`h_cnt`==0, `v_cnt`==V_ACTIVE), the first blanking line.
- If it is high there, `swap` is 1 for exactly one clk; otherwise no swap that frame.
- A `frame_ready` rising in that same cycle is accepted.
- A `frame_ready` that is still high in the next frame after a swap triggers another swap. The writer must drop it after `swap`.
- A swap is never issued while any active pixel is in the pipeline.

**Reset**
- `rst_n` low at any time (mid-line or mid-frame) clears all state immediately:
  - counters 0, `rad` 0, `swap` 0, `frame_start` 0;
  - `lcd_data` 0, `lcd_de` 0;
  - `lcd_hsync` 1, `lcd_vsync` 1.
- After release, scanout restarts at (0,0). The first `frame_start` pulse occurs on the first clk after release.

## Timing

**Pipeline**
- S0: counters at (h,v).
- S1: `rad`=A is registered, along with delayed DE, hsync and vsync flags.
- S2: `fb_data` is valid.
- S3: `lcd_*` registers are updated.

**Alignment**
- The pixel with address A appears on `lcd_data` 2 clks after `rad`==A is presented.
- `lcd_de`, `lcd_hsync` and `lcd_vsync` are delayed identically, so all four are mutually aligned.

**Pulses**
- `frame_start` is asserted in the S1 cycle of (0,0); it is registered, 1 clk wide.
- `swap` is registered and asserted the clk after its S0 sample point.

**Throughput**
- One pixel per clk in active regions, with no stalls.
- Frame period is H_TOTAL*V_TOTAL clks.

## Configuration

`LCD_SCANOUT_TESTPAT_EN`:
- **Defined:** adds input port `test_en` (1 bit). While `test_en`=1, `lcd_data` during DE is `h_cnt[7:0]^v_cnt[7:0]`, delayed to the same alignment as `fb_data`; `rad` and `swap` behaviour are unchanged.
- **Undefined:** the port is absent and `lcd_data` always comes from `fb_data`.

## Test plan

All scenarios use small timing: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1 (H_TOTAL=7); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); frame = 42 clks.

1. **Reset values:** hold `rst_n`=0 → `lcd_hsync`=1, `lcd_vsync`=1, `lcd_de`=0, `lcd_data`=0, `rad`=0, `swap`=0. Release → `frame_start` pulses once per 42 clks.
2. **Sync geometry:** free-run 2 frames → per line: `lcd_de` high 4 clks, then 1 clk low, then `lcd_hsync` low 1 clk, then 1 clk low. `lcd_vsync` low for exactly 7 clks per 42. `lcd_de` never high while `lcd_vsync` is low.
3. **Address/data alignment:** framebuffer model returns `fb_data`=A[7:0] one clk after `rad`=A → `lcd_data` reads 0..11 across one frame's DE cycles. `rad` never exceeds 11.
4. **Swap handshake:**
   - `frame_ready`=1 asserted mid-frame → one `swap` pulse, 1 clk after counters reach (0,3); drop `frame_ready` on `swap` → no further swap.
   - `frame_ready` held high → one swap per frame.
   - `frame_ready`=0 → no swap.
5. **Mid-frame reset:** assert `rst_n`=0 at (2,1) for 3 clks → outputs return to reset values at once. After release the next DE burst starts with `rad`=0 and `lcd_data`=0x00 (pattern value 0).
6. **Test pattern:** with `LCD_SCANOUT_TESTPAT_EN` defined and `test_en`=1 → pixel (h=3, v=2) outputs `lcd_data`=0x01.
